// File: rtl/if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_unit
//  Description : Instruction-fetch stage with an integrated byte-addressed
//                instruction memory and a small prefetch queue. The queue
//                decouples PC generation and memory reads from decode through
//                a valid/ready handshake. A jump flushes the queue and
//                redirects the fetch PC. The loader port writes program words.
//
//  Ports       : i_clk, i_reset (sync, active-high)
//                i_halt           freeze everything except reset
//                i_ready          consumer takes the head entry
//                i_jump / i_jump_address          redirect request
//                i_write_instruction_flag / i_address_to_write_inst /
//                i_instruction_to_write           loader write port
//                o_valid, o_instruction, o_pc     queue head
//                o_fifo_level                     entries held
//                o_fetch_count                    delivered instructions
//
//  Build macro : IF_FETCH_COUNTER_EN - builds the delivered-instruction
//                counter; without it o_fetch_count is tied to zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_unit #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] PC_RESET   = 32'h0,
    parameter int          PC_STEP    = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_halt,
    input  logic                          i_ready,
    input  logic                          i_jump,
    input  logic [31:0]                   i_jump_address,
    input  logic                          i_write_instruction_flag,
    input  logic [31:0]                   i_address_to_write_inst,
    input  logic [DATA_WIDTH-1:0]         i_instruction_to_write,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_instruction,
    output logic [31:0]                   o_pc,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [31:0]                   o_fetch_count
);

    localparam int C_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int C_LVL_W     = C_PTR_W + 1;
    localparam int C_MEM_BYTES = 2 ** ADDR_WIDTH;
    localparam logic [C_LVL_W-1:0] C_DEPTH = C_LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Instruction memory: byte array, little-endian words, async read.
    // Address bits above ADDR_WIDTH wrap; bits [1:0] are ignored.
    // ------------------------------------------------------------------
    logic [7:0]            mem_q [0:C_MEM_BYTES-1];
    logic [ADDR_WIDTH-3:0] w_rd_word;
    logic [ADDR_WIDTH-3:0] w_wr_word;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused_wr_addr;

    // Prefetch queue state
    logic [31:0]           pc_fifo_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ins_fifo_q [FIFO_DEPTH];
    logic [C_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [C_LVL_W-1:0]    level_q,  level_d;
    logic [31:0]           fetch_pc_q, fetch_pc_d;

    logic w_valid;
    logic w_pop;
    logic w_push;
    logic w_jump;
    logic w_mem_we;

    assign w_rd_word = fetch_pc_q[ADDR_WIDTH-1:2];
    assign w_wr_word = i_address_to_write_inst[ADDR_WIDTH-1:2];
    assign w_rd_data = {mem_q[{w_rd_word, 2'd3}], mem_q[{w_rd_word, 2'd2}],
                        mem_q[{w_rd_word, 2'd1}], mem_q[{w_rd_word, 2'd0}]};
    assign w_unused_wr_addr = ^{i_address_to_write_inst[31:ADDR_WIDTH],
                                i_address_to_write_inst[1:0]};

    // Halt masks jump and write as well as the queue handshake.
    assign w_valid  = (level_q != '0);
    assign w_jump   = i_jump & ~i_halt;
    assign w_mem_we = i_write_instruction_flag & ~i_halt & ~i_reset;
    assign w_pop    = w_valid & i_ready & ~i_halt & ~i_jump;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push   = ~i_halt & ~i_jump & ~i_write_instruction_flag &
                      ((level_q < C_DEPTH) | w_pop);

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            mem_q[{w_wr_word, 2'd0}] <= i_instruction_to_write[7:0];
            mem_q[{w_wr_word, 2'd1}] <= i_instruction_to_write[15:8];
            mem_q[{w_wr_word, 2'd2}] <= i_instruction_to_write[23:16];
            mem_q[{w_wr_word, 2'd3}] <= i_instruction_to_write[31:24];
        end
    end

    // ------------------------------------------------------------------
    // Queue pointer / level / fetch PC next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        fetch_pc_d = fetch_pc_q;
        if (w_jump) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            fetch_pc_d = i_jump_address;
        end else begin
            if (w_push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            fetch_pc_q <= PC_RESET;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Entry payload needs no reset: the level qualifies every read.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !w_jump && w_push) begin
            pc_fifo_q[wr_ptr_q]  <= fetch_pc_q;
            ins_fifo_q[wr_ptr_q] <= w_rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Head outputs; an empty queue shows a NOP at the current fetch PC.
    // ------------------------------------------------------------------
    assign o_valid       = w_valid;
    assign o_instruction = w_valid ? ins_fifo_q[rd_ptr_q] : '0;
    assign o_pc          = w_valid ? pc_fifo_q[rd_ptr_q] : fetch_pc_q;
    assign o_fifo_level  = level_q;

`ifdef IF_FETCH_COUNTER_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_count_q <= '0;
        end else if (w_pop) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign o_fetch_count = fetch_count_q;
`else
    assign o_fetch_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_prefetch_unit
//  Description : Self-checking bench for if_prefetch_unit. Expected head
//                entries are queued as stimulus is planned and compared as
//                the consumer accepts them; directed checks cover level,
//                flush, halt, loader writes and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        ready = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        wr = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pc;
    logic [2:0]  o_fifo_level;
    logic [31:0] o_fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_accept = 0;

    if_prefetch_unit dut (
        .i_clk                    (clk),
        .i_reset                  (rst),
        .i_halt                   (halt),
        .i_ready                  (ready),
        .i_jump                   (jump),
        .i_jump_address           (jump_addr),
        .i_write_instruction_flag (wr),
        .i_address_to_write_inst  (wr_addr),
        .i_instruction_to_write   (wr_data),
        .o_valid                  (o_valid),
        .o_instruction            (o_instruction),
        .o_pc                     (o_pc),
        .o_fifo_level             (o_fifo_level),
        .o_fetch_count            (o_fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // Program image the bench loads and later expects to read back.
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        case (a)
            32'h000: return 32'h20010005;
            32'h004: return 32'h20020007;
            32'h008: return 32'h00221820;
            32'h100: return 32'hCAFEF00D;
            32'h104: return 32'h0BADBEEF;
            default: return 32'hA0000000 | a;
        endcase
    endfunction

    task automatic sb_push(input logic [31:0] pc);
        exp_q.push_back({pc, ref_word(pc)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Consumer side: every accepted head must match the next planned entry.
    always @(negedge clk) begin
        if (o_valid && ready && !halt && !jump && !rst) begin
            n_accept++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", o_pc, e.pc);
                check("sb_ins", o_instruction, e.ins);
            end
        end
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) cyc();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ins", o_instruction, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_level", 32'(o_fifo_level), 32'd0);
        check("rst_count", o_fetch_count, 32'h0);
        rst = 1'b0;

        // ---------------- load program ----------------
        for (int a = 0; a < 32'h80; a += 4) begin
            wr = 1'b1; wr_addr = 32'(a); wr_data = ref_word(32'(a));
            cyc();
            check("load_no_push", 32'(o_fifo_level), 32'd0);
        end
        wr = 1'b0; ready = 1'b1;
        sb_push(32'h0); sb_push(32'h4); sb_push(32'h8);
        cyc();
        check("first_valid", 32'(o_valid), 32'd1);
        check("first_ins", o_instruction, 32'h20010005);
        check("first_pc", o_pc, 32'h0);
        cyc();
        check("second_pc", o_pc, 32'h4);
        cyc();
        check("third_ins", o_instruction, 32'h00221820);
        cyc();
        ready = 1'b0;

        // ---------------- fill to saturation, then drain ----------------
        jump = 1'b1; jump_addr = 32'h0;
        cyc();
        jump = 1'b0;
        check("refill_level0", 32'(o_fifo_level), 32'd0);
        check("refill_pc", o_pc, 32'h0);
        for (int k = 0; k < 5; k++) sb_push(32'(4 * k));
        repeat (9) cyc();
        check("full_level", 32'(o_fifo_level), 32'd4);
        check("full_head_pc", o_pc, 32'h0);
        check("full_head_ins", o_instruction, 32'h20010005);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 32'(o_valid), 32'd1);
            check("drain_pc", o_pc, 32'(4 * i));
            cyc();
        end
        ready = 1'b0;

        // ---------------- jump at level 3 ----------------
        jump = 1'b1; jump_addr = 32'h20;
        cyc();
        jump = 1'b0;
        repeat (3) cyc();
        check("pre_jump_level", 32'(o_fifo_level), 32'd3);
        ready = 1'b1; jump = 1'b1; jump_addr = 32'h40;
        sb_push(32'h40); sb_push(32'h44); sb_push(32'h48);
        cyc();
        jump = 1'b0;
        check("jump_level", 32'(o_fifo_level), 32'd0);
        check("jump_valid", 32'(o_valid), 32'd0);
        check("jump_pc", o_pc, 32'h40);
        cyc();
        check("jump_valid1", 32'(o_valid), 32'd1);
        check("jump_head_pc", o_pc, 32'h40);
        check("jump_head_ins", o_instruction, ref_word(32'h40));
        repeat (3) cyc();
        check("pre_halt_pc", o_pc, 32'h4C);

        // ---------------- halt with jump and write attempts ----------------
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            jump = (i == 1 || i == 3); jump_addr = 32'h200;
            wr = (i == 2); wr_addr = 32'h0; wr_data = 32'hDEADBEEF;
            cyc();
            check("halt_pc", o_pc, 32'h4C);
            check("halt_ins", o_instruction, ref_word(32'h4C));
            check("halt_level", 32'(o_fifo_level), 32'd1);
        end
        halt = 1'b0; jump = 1'b0; wr = 1'b0;
        sb_push(32'h4C); sb_push(32'h50); sb_push(32'h54); sb_push(32'h58);
        repeat (3) cyc();
        check("resume_pc", o_pc, 32'h58);

        // ---------------- loader write mid-stream ----------------
        wr = 1'b1; wr_addr = 32'h100; wr_data = ref_word(32'h100);
        cyc();
        check("wr_level", 32'(o_fifo_level), 32'd0);
        check("wr_valid", 32'(o_valid), 32'd0);
        check("wr_fetch_pc", o_pc, 32'h5C);
        wr_addr = 32'h104; wr_data = ref_word(32'h104);
        cyc();
        check("wr_fetch_pc2", o_pc, 32'h5C);
        check("wr_level2", 32'(o_fifo_level), 32'd0);
        wr = 1'b0; jump = 1'b1; jump_addr = 32'h100;
        sb_push(32'h100); sb_push(32'h104);
        cyc();
        jump = 1'b0;
        cyc();
        check("wr_readback", o_instruction, 32'hCAFEF00D);
        repeat (2) cyc();
        ready = 1'b0;

        // ---------------- reset while full ----------------
        jump = 1'b1; jump_addr = 32'h14;
        cyc();
        jump = 1'b0;
        repeat (4) cyc();
        check("prerst_level", 32'(o_fifo_level), 32'd4);
        check("prerst_pc", o_pc, 32'h14);
`ifdef IF_FETCH_COUNTER_EN
        check("fetch_count", o_fetch_count, 32'(n_accept));
`else
        check("fetch_count", o_fetch_count, 32'h0);
`endif
        rst = 1'b1;
        cyc();
        check("mrst_level", 32'(o_fifo_level), 32'd0);
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_pc", o_pc, 32'h0);
        check("mrst_ins", o_instruction, 32'h0);
        check("mrst_count", o_fetch_count, 32'h0);
        rst = 1'b0; ready = 1'b1;
        sb_push(32'h0);
        cyc();
        check("mem_kept_pc", o_pc, 32'h0);
        check("mem_kept_ins", o_instruction, 32'h20010005);
        cyc();
        ready = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
